// File: rtl/pkt_grant_lock_mux_pkg.sv
// arb_pkg: shared types, defaults and the grant-encoding helper for the packet-lock mux.
package arb_pkg;
   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF = 32;
   typedef enum logic {IDLE, LOCKED} state_t;
   function automatic int onehot_to_idx(input logic [31:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
      return idx;
   endfunction
endpackage

// File: rtl/pkt_grant_lock_mux_if.sv
// pkt_grant_lock_mux_if: requester-side and output-side stream signals of the packet mux.
interface pkt_grant_lock_mux_if import arb_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0] in_valid;
   logic [NUM_REQ*DATA_W-1:0] in_data;
   logic [NUM_REQ-1:0] in_last;
   logic [NUM_REQ-1:0] in_ready;
   logic out_valid;
   logic [DATA_W-1:0] out_data;
   logic out_last;
   logic out_ready;
   logic [SRC_W-1:0] out_src;
   logic busy;
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input in_ready, out_valid, out_data, out_last, out_src, busy
   );
   modport slave (
      input in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_src, busy
   );
endinterface

// File: rtl/pkt_grant_lock_mux_arbiter.sv
// fixed_priority_arbiter: combinational one-hot grant, bit 0 has highest priority.
module fixed_priority_arbiter #(
   parameter int arbi_width = 4
) (
   input logic [arbi_width-1:0] req,
   output logic [arbi_width-1:0] grant
);
   assign grant = req & (~req + arbi_width'(1));
endmodule

// File: rtl/pkt_grant_lock_mux.sv
// pkt_grant_lock_mux: locks the arbiter's winner for a whole packet and muxes its stream out.
module pkt_grant_lock_mux import arb_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic clk,
   input logic rst_n,
   pkt_grant_lock_mux_if.slave bus
);
   state_t state_q, state_d;
   logic [NUM_REQ-1:0] grant, grant_q;
   logic [SRC_W-1:0] src_q;
   logic [DATA_W-1:0] lanes [NUM_REQ];
   logic locked, xfer_last;
   fixed_priority_arbiter #(.arbi_width(NUM_REQ)) u_arb (.req(bus.in_valid), .grant(grant));
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lanes[g] = bus.in_data[g*DATA_W +: DATA_W];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         src_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && |bus.in_valid) begin
            grant_q <= grant;
            src_q <= SRC_W'(onehot_to_idx(32'(grant)));
         end else if (xfer_last) begin
            grant_q <= '0;
         end
      end
   end
   // Release only after the last beat is accepted; the release edge never re-samples requests.
   always_comb state_d = (state_q == IDLE) ? ((|bus.in_valid) ? LOCKED : IDLE) : (xfer_last ? IDLE : LOCKED);
   always_comb begin
      locked = state_q == LOCKED;
      bus.out_valid = locked & bus.in_valid[src_q];
      bus.out_last = locked & bus.in_last[src_q];
      bus.out_data = locked ? lanes[src_q] : '0;
      bus.in_ready = (locked & bus.out_ready) ? grant_q : '0;
      bus.out_src = src_q;
      bus.busy = locked;
      xfer_last = bus.out_valid & bus.out_ready & bus.out_last;
   end
endmodule

// File: tb/tb_pkt_grant_lock_mux.sv
// tb_pkt_grant_lock_mux: randomized scenarios checked against a packet-owner reference model.
module tb_pkt_grant_lock_mux;
   import arb_pkg::*;
   localparam int N = 4;
   localparam int DW = 32;
   localparam int SW = 2;
   localparam int VW = 3 + N + DW + SW;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int owner = -1;
   logic [DW:0] q[N][$];
   logic [N-1:0] gap = '0;
   logic [DW-1:0] got[$];

   always #5 clk = ~clk;

   pkt_grant_lock_mux_if #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) bus ();
   pkt_grant_lock_mux #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: owner is the requester holding the output, -1 when nobody does.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) owner <= -1;
      else if (owner < 0) owner <= lowest(bus.in_valid);
      else if (bus.in_valid[owner] && bus.out_ready && bus.in_last[owner]) owner <= -1;

   function automatic logic [VW-1:0] model_vec();
      logic lk;
      int s;
      lk = owner >= 0;
      s = lk ? owner : 0;
      return {lk, lk & bus.in_valid[s], lk & bus.in_last[s], (lk & bus.out_ready) ? N'(1 << s) : N'(0),
              lk ? bus.in_data[s*DW +: DW] : DW'(0), lk ? SW'(s) : SW'(0)};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.busy, bus.out_valid, bus.out_last, bus.in_ready, bus.out_data, bus.busy ? bus.out_src : SW'(0)};
   endfunction

   function automatic logic done();
      logic e;
      e = owner < 0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) e = 1'b0;
      return e;
   endfunction

   task automatic add_pkt(input int src, input int len);
      logic [DW-1:0] d;
      for (int k = 0; k < len; k++) begin
         d = $urandom;
         q[src].push_back({k == len - 1, d});
      end
   endtask

   task automatic drive();
      logic [DW:0] b;
      for (int i = 0; i < N; i++) begin
         b = q[i].size() > 0 ? q[i][0] : {1'($urandom), DW'($urandom)};
         bus.in_valid[i] = q[i].size() > 0 && !gap[i];
         bus.in_data[i*DW +: DW] = b[DW-1:0];
         bus.in_last[i] = b[DW];
      end
   endtask

   task automatic step();
      logic [N-1:0] fire;
      fire = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire[i]) void'(q[i].pop_front());
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = '1;
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      bus.in_last = '1;
      @(negedge clk);
      total++;
      if (dut_vec() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", dut_vec()); end
      total++;
      if (bus.out_src !== '0) begin bad++; $display("FAIL reset_src got=%0d exp=0", bus.out_src); end
      @(posedge clk);
      #1;
      drive();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      q[2].push_back({1'b0, 32'hA0});
      q[2].push_back({1'b0, 32'hA1});
      q[2].push_back({1'b1, 32'hA2});
      bus.out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         drive();
         @(negedge clk);
         total++;
         if (bus.busy !== (c >= 1 && c <= 3)) begin bad++; $display("FAIL single_busy c=%0d got=%b", c, bus.busy); end
         if (c >= 1 && c <= 3) begin
            total++;
            if ({bus.out_src, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data} !== {2'd2, 4'b0100, 1'b1, c == 3, 32'hA0 + 32'(c - 1)})
               begin bad++; $display("FAIL single_beat c=%0d got src=%0d rdy=%b v=%b l=%b d=%h", c, bus.out_src, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data); end
         end
         step();
      end
      total++;
      if (!done()) begin bad++; $display("FAIL single_drain got=busy exp=idle"); end
   endtask

   task automatic test_contention();
      int code = 0, idle = 0;
      logic was = 1'b0;
      add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2);
      for (int c = 0; c < 40 && !done(); c++) begin
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL contention_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         if (bus.busy && !was) begin
            code = code * 16 + int'(bus.out_src) + 1;
            total++;
            if (idle != 1) begin bad++; $display("FAIL contention_bubble got=%0d exp=1", idle); end
         end
         idle = bus.busy ? 0 : idle + 1;
         was = bus.busy;
         step();
      end
      total++;
      if (code != 'h124 || !done()) begin bad++; $display("FAIL contention_order got=%h exp=124", code); end
   endtask

   task automatic test_no_preempt();
      int code = 0, idle = 0;
      logic was = 1'b0, added = 1'b0;
      add_pkt(2, 4);
      for (int c = 0; c < 40 && !done(); c++) begin
         if (!added && q[2].size() == 3) begin add_pkt(0, 2); added = 1'b1; end
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL preempt_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         if (bus.busy && !was) begin
            code = code * 16 + int'(bus.out_src) + 1;
            total++;
            if (idle != 1) begin bad++; $display("FAIL preempt_bubble got=%0d exp=1", idle); end
         end
         idle = bus.busy ? 0 : idle + 1;
         was = bus.busy;
         step();
      end
      total++;
      if (code != 'h31 || !done()) begin bad++; $display("FAIL preempt_order got=%h exp=31", code); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] want[$];
      logic [DW:0] b;
      logic [3:0] pat = 4'b1001;
      got.delete();
      add_pkt(1, 4);
      for (int k = 0; k < 4; k++) begin b = q[1][k]; want.push_back(b[DW-1:0]); end
      for (int c = 0; c < 60 && !done(); c++) begin
         if (c == 2) begin
            add_pkt(3, 2);
            for (int k = 0; k < 2; k++) begin b = q[3][k]; want.push_back(b[DW-1:0]); end
         end
         bus.out_ready = pat[c % 4];
         gap[1] = c == 3 || c == 4;
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL backpressure_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         step();
      end
      gap = '0;
      total++;
      if (got.size() != want.size() || !done()) begin bad++; $display("FAIL backpressure_count got=%0d exp=%0d", got.size(), want.size()); end
      for (int k = 0; k < want.size() && k < got.size(); k++) begin
         total++;
         if (got[k] !== want[k]) begin bad++; $display("FAIL backpressure_data k=%0d got=%h exp=%h", k, got[k], want[k]); end
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) add_pkt(3, 1);
      for (int c = 0; c < 30 && !done(); c++) begin
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL b2b_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         total++;
         if (bus.busy !== 1'(c % 2) || (bus.busy && (bus.out_last !== 1'b1 || bus.out_src !== 2'd3)))
            begin bad++; $display("FAIL b2b_cycle c=%0d got busy=%b last=%b src=%0d", c, bus.busy, bus.out_last, bus.out_src); end
         step();
      end
      total++;
      if (!done()) begin bad++; $display("FAIL b2b_drain got=busy exp=idle"); end
   endtask

   task automatic test_reset_mid();
      logic hit = 1'b0;
      bus.out_ready = 1'b1;
      add_pkt(1, 4);
      for (int c = 0; c < 10 && !hit; c++) begin
         drive();
         @(negedge clk);
         if (bus.busy && q[1].size() == 3) begin
            hit = 1'b1;
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({bus.out_valid, bus.busy, bus.in_ready} !== '0)
               begin bad++; $display("FAIL reset_mid got v=%b busy=%b rdy=%b exp=0", bus.out_valid, bus.busy, bus.in_ready); end
         end else step();
      end
      total++;
      if (!hit) begin bad++; $display("FAIL reset_mid_reach got=0 exp=1"); end
      q[1].delete();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      add_pkt(1, 2);
      for (int c = 0; c < 20 && !done(); c++) begin
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL rearb_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         if (c == 1) begin
            total++;
            if (bus.busy !== 1'b1 || bus.out_src !== 2'd1) begin bad++; $display("FAIL rearb_src got busy=%b src=%0d exp 1/1", bus.busy, bus.out_src); end
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(3) == 0) begin
            int s = $urandom_range(N - 1);
            if (q[s].size() == 0) add_pkt(s, $urandom_range(4, 1));
         end
         gap = N'($urandom) & N'($urandom);
         bus.out_ready = $urandom_range(3) != 0;
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL random_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         step();
      end
      gap = '0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 200 && !done(); c++) begin
         drive();
         @(negedge clk);
         total++;
         if (dut_vec() !== model_vec()) begin bad++; $display("FAIL drain_vec c=%0d got=%h exp=%h", c, dut_vec(), model_vec()); end
         step();
      end
      total++;
      if (!done()) begin bad++; $display("FAIL random_drain got=busy exp=idle"); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_no_preempt();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pkt_grant_lock_mux.md
Name: pkt_grant_lock_mux

Overview:
- Packet-level N:1 stream multiplexer that consumes one-hot grants from the combinational fixed-priority arbiter (instance fixed_priority_arbiter, bit 0 highest priority).
- Registers the winning grant and holds it for the full packet, from the first beat to the accepted `last` beat, then releases it for re-arbitration.
- Sits directly downstream of the arbiter and drives a single valid/ready/last output channel toward the shared resource.

Parameters:
- NUM_REQ, 4, number of requesters; also the arbiter width.
- DATA_W, 32, data width per beat.
- SRC_W, $clog2(NUM_REQ) (minimum 1), width of the source index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_REQ  per-requester beat valid; this is the arbiter's req vector.
- in_data  in  NUM_REQ*DATA_W  packed data; requester i occupies [i*DATA_W +: DATA_W].
- in_last  in  NUM_REQ  per-requester end-of-packet flag.
- in_ready  out  NUM_REQ  per-requester ready.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat data.
- out_last  out  1  output end-of-packet flag.
- out_ready  in  1  downstream ready.
- out_src  out  SRC_W  index of the locked requester.
- busy  out  1  1 while in LOCKED.

Behaviour:
- FSM has two states, IDLE and LOCKED, plus registered state grant_q[NUM_REQ] (one-hot or zero) and src_q[SRC_W].
- Reset (asynchronous, rst_n=0):
  - state=IDLE, grant_q=0, src_q=0.
  - Outputs: out_valid=0, in_ready=0, busy=0, out_src=0, out_last=0, out_data=0.
- IDLE:
  - in_ready=0 and out_valid=0.
  - The arbiter's grant is computed from in_valid.
  - If |in_valid, the next edge loads grant_q with that grant, loads src_q with the encoded index, and moves to LOCKED.
  - Arbitration latency: 1 cycle from a request being seen in IDLE to LOCKED.
- LOCKED, with s=src_q:
  - out_valid=in_valid[s], out_data=in_data[s], out_last=in_last[s].
  - in_ready[s]=out_ready; all other in_ready bits are 0.
  - The path from in_* to out_* is purely combinational, so there is zero added data latency.
  - A beat transfers when out_valid & out_ready.
  - If the transferred beat has out_last=1, the next edge goes to IDLE and clears grant_q.
  - Result: there is always exactly one idle bubble cycle between packets.
- Locked requester drops in_valid mid-packet: the lock holds, out_valid=0, and no other requester is served until its `last` is accepted.
- Higher-priority request arriving during LOCKED: no preemption; it is considered in the next IDLE cycle.
- Release and new requests in the same cycle: new requests are not sampled on the release edge; they are arbitrated in the following IDLE cycle.
- Fixed priority: with continuous requests, lower indices can starve higher indices. This is intended.
- Single-beat packet (in_last=1 on the first beat): LOCKED lasts exactly one cycle if out_ready=1.
- out_ready=0 while locked: the beat is held; out_data and out_last must stay stable as long as the source holds them (no internal buffering).
- Reset asserted mid-packet: returns immediately to IDLE, out_valid drops asynchronously, and the partial packet is abandoned (recovery is the source's job).
- Unused in_data lanes have no effect on outputs.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE, LOCKED);
  - a onehot-to-index function used for src_q;
  - default NUM_REQ/DATA_W constants.
- One sub-module: the existing fixed_priority_arbiter, instanced with arbi_width=NUM_REQ and req=in_valid.
- Data multiplexing is by src_q indexing and needs no further sub-module.

Test Plan:
- Single packet: in_valid=4'b0100, 3-beat packet with data 0xA0..0xA2 and `last` on beat 3, out_ready=1.
  - Expect busy=1 and out_src=2 one cycle after the request.
  - Expect three output beats on consecutive cycles and in_ready=4'b0100 during them.
  - Expect IDLE after the third beat.
- Contention: in_valid=4'b1011, all with 2-beat packets and held valid.
  - Expect service order src 0, 1, 3.
  - Expect exactly one bubble cycle (busy=0) between packets.
- No preemption: lock src 2 on a 4-beat packet, then raise in_valid[0] at beat 2.
  - Expect src 2 to complete all 4 beats, then src 0 to be granted after one IDLE cycle.
- Backpressure and gaps: locked src 1, out_ready toggling 1,0,0,1 while in_valid[1] drops for 2 cycles mid-packet.
  - Expect beats transferred only on valid&ready, no data loss or duplication, busy=1 throughout, in_ready of other requesters 0.
- Single-beat back-to-back: src 3 sends 1-beat packets continuously, out_ready=1.
  - Expect a grant every 2 cycles (LOCKED, IDLE alternating) with out_last=1 on every beat.
- Reset mid-packet: assert rst_n=0 during beat 2 of a 4-beat packet from src 1.
  - Expect out_valid, busy and in_ready to be 0 immediately.
  - After release with in_valid=4'b0010, expect re-arbitration in 1 cycle and out_src=1.
